fifo_rd_unpack_16to8: RTL and testbench
=======================================

# fifo_rd_unpack_16to8

Read-side drain engine for the 16-bit output port of the 8-in/16-out FIFO. It issues `fifo_rd_en` against the FIFO's empty flag and absorbs the FIFO's registered read latency in a 4-entry word buffer. Each 16-bit word is split into two 8-bit beats on a valid/ready byte stream. It sits between the FIFO read port and any byte-wide consumer, such as a UART/serial TX or a byte-oriented DMA path.

## Interface
- `RD_LATENCY`, 1 — cycles from `fifo_rd_en` to valid `fifo_rd_data`. Legal values: 1 (no FIFO output register) or 2 (FIFO output register enabled).
- `LSB_FIRST`, 1 — 1: emit bits [7:0] first, then [15:8]. 0: emit [15:8] first.
- `rd_clk`  in  1  single clock for the block.
- `rd_rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous clear of the buffer, byte phase and in-flight reads.
- `fifo_rd_data`  in  16  FIFO read data.
- `fifo_rd_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read enable, combinational.
- `m_data`  out  8  output byte.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  consumer accepts the byte.
- `m_odd`  out  1  1 when the current beat is the second byte of its word.
- `buf_level`  out  3  words held in the buffer, 0..4.

## Operation
- **Reset values.** `m_valid`=0, `m_data`=0x00, `m_odd`=0, `buf_level`=0, in-flight count=0, byte phase=0, `fifo_rd_en`=0.
- **Credit rule.**
  - `fifo_rd_en` = `!fifo_rd_empty && !flush && (buf_level + inflight) < 4`.
  - `inflight` is a 2-bit count of reads issued whose data has not yet returned.
  - `fifo_rd_en` is never asserted while `fifo_rd_empty`=1.
- **Return pipeline.**
  - A RD_LATENCY-deep valid shift register tracks issued reads.
  - When its tail is 1, `fifo_rd_data` is written into the buffer tail, `buf_level` increments and `inflight` decrements.
- **Buffer.**
  - 4-entry circular buffer with 2-bit write and read pointers; the pointers wrap from 3 to 0.
  - Overflow is impossible by construction of the credit rule. The bench asserts that a write never occurs with `buf_level`=4 and no same-cycle pop.
- **Byte phase FSM.** Two states, BYTE0 and BYTE1.
  - `m_valid` = (`buf_level` != 0).
  - `m_data` = selected half of the head word. In BYTE0 it is [7:0] when `LSB_FIRST`=1, else [15:8]; BYTE1 gives the other half.
  - `m_odd` = (state == BYTE1).
  - BYTE0 → BYTE1 on `m_valid && m_ready`.
  - BYTE1 → BYTE0 on `m_valid && m_ready`; this handshake also pops the head word.
  - The state holds while `m_ready`=0. `m_data` is stable while `m_valid && !m_ready`.
- **Simultaneous push and pop.** `buf_level` is unchanged and both pointers advance.
- **Flush.**
  - In the flush cycle: `buf_level`→0, pointers→0, state→BYTE0, and the valid shift register is cleared.
  - Data returning after a flush for reads issued before it is discarded.
  - `m_valid`=0 from the cycle after `flush`.
  - `flush` has priority over a push or pop in the same cycle.
- **Async reset mid-operation.** All state clears immediately. A FIFO read already issued is lost; that word is dropped by design, and the FIFO is reset together with this block.

## Timing
- **Latency.**
  - `fifo_rd_en` at cycle t gives data captured at the end of t+RD_LATENCY.
  - `m_valid` rises at t+RD_LATENCY+1, which is 2 cycles for L=1 and 3 cycles for L=2.
- **Throughput.**
  - With `m_ready`=1 and the FIFO non-empty, the output sustains 1 byte/cycle (1 word per 2 cycles) for both latencies with no bubbles after the first byte.
  - The 4-entry buffer covers L=2 plus the credit round trip.
- **Empty.** When the FIFO goes empty, the buffered words drain. `m_valid` falls in the cycle after the final BYTE1 handshake.
- **Registering.** `fifo_rd_en` and `m_data` are combinational; all state is registered on `rd_clk`.

## Test plan
- **Reset.** Assert `rd_rst_n`=0 mid-stream with `buf_level`=3. Required: `m_valid`, `m_odd`, `buf_level` and `fifo_rd_en` all 0 immediately. After release, the first `fifo_rd_en` occurs only when `fifo_rd_empty`=0.
- **LSB-first streaming.** `LSB_FIRST`=1, L=1, FIFO holds 0x1234 and 0x5678, `m_ready`=1. Required: bytes 0x34, 0x12, 0x78, 0x56 on 4 consecutive cycles, with `m_odd` = 0,1,0,1. The first `m_valid` is 2 cycles after the first `fifo_rd_en`.
- **MSB-first streaming.** `LSB_FIRST`=0, L=2, 64 words streamed with `m_ready`=1. Required: the bytes 0x12, 0x34, ... arrive in order; no bubble occurs between the first and last byte; `m_valid` first rises 3 cycles after the first `fifo_rd_en`.
- **Backpressure.** Random `m_ready`, 1000 words. Required: output equals input byte-split with no loss or duplication. `buf_level + inflight` never exceeds 4. `m_data` is stable while `m_valid && !m_ready`.
- **Empty gating.** Hold `fifo_rd_empty`=1 for 50 cycles with credits free. Required: `fifo_rd_en`=0 throughout. After the buffer drains, `m_valid`=0.
- **Flush.** Assert `flush` in BYTE1 with 2 reads in flight at L=2. Required: `m_valid`=0 and `buf_level`=0 next cycle. Both returning words are discarded. The next word fetched is emitted starting in BYTE0.

Source files
------------

// File: rtl/fifo_rd_unpack_16to8_if.sv
// Bundle between the FIFO read port, the drain engine and a byte-wide consumer.
// master: the drain engine. slave: the FIFO/consumer side.
interface fifo_rd_unpack_16to8_if;
  logic        flush;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic        fifo_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_odd;
  logic [2:0]  buf_level;

  modport master (
    input  flush,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output m_odd,
    output buf_level
  );

  modport slave (
    output flush,
    output fifo_rd_data,
    output fifo_rd_empty,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  m_odd,
    input  buf_level
  );
endinterface

// File: rtl/fifo_rd_unpack_16to8.sv
// Drains 16-bit words from a FIFO read port with registered read latency and
// presents them as two 8-bit beats on a valid/ready stream. A 4-entry buffer plus
// a credit count (buffered + in-flight words) keeps reads from ever overflowing.
// RD_LATENCY must be 1 or 2.
module fifo_rd_unpack_16to8 #(
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input logic                    rd_clk,
  input logic                    rd_rst_n,
  fifo_rd_unpack_16to8_if.master bus
);

  typedef enum logic {StByte0, StByte1} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             mem_q [4];
  logic [1:0]              wptr_q, wptr_d;
  logic [1:0]              rptr_q, rptr_d;
  logic [2:0]              level_q, level_d;
  logic [1:0]              inflight_q, inflight_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;

  logic        rd_en;
  logic        tail;
  logic        push;
  logic        pop;
  logic        hs;
  logic        valid;
  logic        sel_low;
  logic [3:0]  credits_used;
  logic [15:0] head;

  // Credit: every word either buffered or still in the read pipe holds a slot.
  assign credits_used = {1'b0, level_q} + {2'b00, inflight_q};
  // Gated by reset so no read escapes while the block is held in reset.
  assign rd_en = rd_rst_n && !bus.fifo_rd_empty && !bus.flush && (credits_used < 4'd4);
  assign tail  = vld_q[RD_LATENCY-1];
  assign push  = tail && !bus.flush;
  assign valid = (level_q != 3'd0);
  assign hs    = valid && bus.m_ready;
  assign pop   = hs && (state_q == StByte1) && !bus.flush;

  assign head    = mem_q[rptr_q];
  assign sel_low = ((state_q == StByte0) == LSB_FIRST);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = sel_low ? head[7:0] : head[15:8];
  assign bus.m_odd      = (state_q == StByte1);
  assign bus.buf_level  = level_q;

  // Read-return pipe, pointers, level and in-flight count next state.
  always_comb begin
    vld_d      = '0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    inflight_d = inflight_q;
    if (bus.flush) begin
      // Reads already issued come back into a cleared pipe and are dropped.
      wptr_d     = 2'd0;
      rptr_d     = 2'd0;
      level_d    = 3'd0;
      inflight_d = 2'd0;
    end else begin
      vld_d[0] = rd_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
      inflight_d = inflight_q + 2'(rd_en) - 2'(tail);
      if (push) wptr_d = wptr_q + 2'd1;
      if (pop)  rptr_d = rptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   level_d = level_q + 3'd1;
        2'b01:   level_d = level_q - 3'd1;
        default: level_d = level_q;
      endcase
    end
  end

  // Byte phase: advance on each accepted beat, restart at the low/high first half on flush.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StByte0;
    end else if (hs) begin
      unique case (state_q)
        StByte0: state_d = StByte1;
        StByte1: state_d = StByte0;
        default: state_d = StByte0;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= StByte0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      level_q    <= 3'd0;
      inflight_q <= 2'd0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
    end
  end

  // Word buffer; cleared on reset so m_data idles at 0x00.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (push) begin
      mem_q[wptr_q] <= bus.fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpack_16to8.sv
// Bench for fifo_rd_unpack_16to8: channel 0 is RD_LATENCY=1/LSB-first, channel 1 is
// RD_LATENCY=2/MSB-first. One channel is active at a time and shares a FIFO model.
module tb_fifo_rd_unpack_16to8;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_unpack_16to8_if bus_a ();
  fifo_rd_unpack_16to8_if bus_b ();

  fifo_rd_unpack_16to8 #(.RD_LATENCY(1), .LSB_FIRST(1'b1)) u_dut_a (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .bus      (bus_a)
  );

  fifo_rd_unpack_16to8 #(.RD_LATENCY(2), .LSB_FIRST(1'b0)) u_dut_b (
    .rd_clk   (clk),
    .rd_rst_n (rst_n),
    .bus      (bus_b)
  );

  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic bit lsb(int k);
    return (k == 0);
  endfunction

  // Bench-side drive and model state
  logic        ready_r [NCH] = '{1'b0, 1'b0};
  logic        flush_r [NCH] = '{1'b0, 1'b0};
  logic        hold_r  [NCH] = '{1'b0, 1'b0};
  logic        empty_r [NCH] = '{1'b1, 1'b1};
  logic [15:0] s0_r    [NCH] = '{16'h0, 16'h0};
  logic [15:0] s1_r    [NCH] = '{16'h0, 16'h0};
  int          active = 0;
  logic [15:0] fq [$];

  assign bus_a.m_ready       = ready_r[0];
  assign bus_a.flush         = flush_r[0];
  assign bus_a.fifo_rd_empty = empty_r[0];
  assign bus_a.fifo_rd_data  = s0_r[0];
  assign bus_b.m_ready       = ready_r[1];
  assign bus_b.flush         = flush_r[1];
  assign bus_b.fifo_rd_empty = empty_r[1];
  assign bus_b.fifo_rd_data  = s1_r[1];

  logic       rd_en_w [NCH];
  logic       valid_w [NCH];
  logic       odd_w   [NCH];
  logic [7:0] data_w  [NCH];
  logic [2:0] level_w [NCH];
  assign rd_en_w[0] = bus_a.fifo_rd_en;
  assign rd_en_w[1] = bus_b.fifo_rd_en;
  assign valid_w[0] = bus_a.m_valid;
  assign valid_w[1] = bus_b.m_valid;
  assign odd_w[0]   = bus_a.m_odd;
  assign odd_w[1]   = bus_b.m_odd;
  assign data_w[0]  = bus_a.m_data;
  assign data_w[1]  = bus_b.m_data;
  assign level_w[0] = bus_a.buf_level;
  assign level_w[1] = bus_b.buf_level;

  // Scoreboard
  typedef struct packed {
    logic [7:0] data;
    logic       odd;
  } exp_t;
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_rd, first_v, first_hs, last_hs, hs_cnt, rd_cnt;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read with 1 or 2 cycles of latency, registered empty flag.
  always @(posedge clk) begin : p_fifo_model
    logic [15:0] w;
    for (int k = 0; k < NCH; k++) begin
      w = 16'hdead;
      if (rd_en_w[k] && fq.size() != 0) w = fq.pop_front();
      s0_r[k] <= w;
      s1_r[k] <= s0_r[k];
    end
    for (int k = 0; k < NCH; k++) begin
      empty_r[k] <= (k != active) || hold_r[k] || (fq.size() == 0);
    end
  end

  // Monitor: output compare, stability, credit bound, empty gating.
  logic [1:0] hist       [NCH] = '{2'b00, 2'b00};
  logic       stall_q    [NCH] = '{1'b0, 1'b0};
  logic [7:0] stall_data [NCH] = '{8'h0, 8'h0};
  logic       stall_odd  [NCH] = '{1'b0, 1'b0};

  always @(negedge clk) begin : p_monitor
    int   infl;
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      if (!rst_n) begin
        hist[k]    = 2'b00;
        stall_q[k] = 1'b0;
      end else begin
        if (rd_en_w[k]) check("rd_en_while_empty", 32'(empty_r[k]), 32'd0);
        infl = int'(hist[k][0]) + ((lat(k) == 2) ? int'(hist[k][1]) : 0);
        check("credit_bound", 32'(int'(level_w[k]) + infl <= 4), 32'd1);
        if (stall_q[k] && valid_w[k]) begin
          check("stall_data_stable", 32'(data_w[k]), 32'(stall_data[k]));
          check("stall_odd_stable", 32'(odd_w[k]), 32'(stall_odd[k]));
        end
        if (valid_w[k] && ready_r[k]) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h on ch%0d, expected none", data_w[k], k);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", 32'(data_w[k]), 32'(e.data));
            check("byte_odd", 32'(odd_w[k]), 32'(e.odd));
          end
        end
        if (k == active) begin
          if (rd_en_w[k]) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
          end
          if (valid_w[k] && first_v < 0) first_v = cyc;
        end
        hist[k]       = {hist[k][0], rd_en_w[k]};
        stall_q[k]    = valid_w[k] && !ready_r[k];
        stall_data[k] = data_w[k];
        stall_odd[k]  = odd_w[k];
      end
    end
  end

  // Stimulus helpers
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    first_rd = -1;
    first_v  = -1;
    first_hs = -1;
    last_hs  = -1;
    hs_cnt   = 0;
    rd_cnt   = 0;
  endtask

  task automatic push_word(logic [15:0] w);
    exp_t lo, hi;
    fq.push_back(w);
    lo.data = lsb(active) ? w[7:0] : w[15:8];
    lo.odd  = 1'b0;
    hi.data = lsb(active) ? w[15:8] : w[7:0];
    hi.odd  = 1'b1;
    exp_q.push_back(lo);
    exp_q.push_back(hi);
  endtask

  task automatic wait_drain(int budget, string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid_w[active]) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && !valid_w[active]), 32'd1);
  endtask

  task automatic random_stream(int ch, int words, int budget);
    int n = 0;
    active = ch;
    mark();
    for (int i = 0; i < words; i++) push_word(16'($urandom));
    while ((exp_q.size() != 0 || valid_w[ch]) && n < budget) begin
      ready_r[ch] = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    ready_r[ch] = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_byte_count", 32'(hs_cnt), 32'(2 * words));
  endtask

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : p_stim
    int n;
    mark();
    tick(3);
    for (int k = 0; k < NCH; k++) begin
      check("rst_m_valid", 32'(valid_w[k]), 32'd0);
      check("rst_m_odd", 32'(odd_w[k]), 32'd0);
      check("rst_buf_level", 32'(level_w[k]), 32'd0);
      check("rst_rd_en", 32'(rd_en_w[k]), 32'd0);
      check("rst_m_data", 32'(data_w[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick(2);

    // LSB-first, L=1: 0x34 0x12 0x78 0x56 back to back
    active = 0;
    ready_r[0] = 1'b1;
    mark();
    push_word(16'h1234);
    push_word(16'h5678);
    n = 0;
    while (hs_cnt < 4 && n < 30) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("lsb_byte_count", 32'(hs_cnt), 32'd4);
    check("lsb_consecutive", 32'(last_hs - first_hs), 32'd3);
    check("lsb_latency", 32'(first_v - first_rd), 32'd2);
    check("lsb_valid_falls", 32'(valid_w[0]), 32'd0);
    ready_r[0] = 1'b0;
    tick(2);

    // MSB-first, L=2: 64 words, no bubbles
    active = 1;
    ready_r[1] = 1'b1;
    mark();
    for (int i = 0; i < 64; i++) push_word(16'h1234 + 16'(i) * 16'h0202);
    wait_drain(400, "msb_drained");
    check("msb_byte_count", 32'(hs_cnt), 32'd128);
    check("msb_no_bubble", 32'(last_hs - first_hs), 32'd127);
    check("msb_latency", 32'(first_v - first_rd), 32'd3);
    ready_r[1] = 1'b0;
    tick(2);

    // Backpressure on both latencies
    random_stream(1, 1000, 20000);
    random_stream(0, 200, 5000);
    tick(2);

    // Empty gating: buffered words drain, held-back FIFO is never read
    active = 0;
    ready_r[0] = 1'b0;
    mark();
    push_word(16'hA0A1);
    push_word(16'hB0B1);
    tick(8);
    check("gate_buffered", 32'(level_w[0]), 32'd2);
    hold_r[0] = 1'b1;
    push_word(16'hC0C1);
    push_word(16'hD0D1);
    tick(2);
    ready_r[0] = 1'b1;
    n = rd_cnt;
    tick(50);
    check("gate_no_reads", 32'(rd_cnt - n), 32'd0);
    check("gate_valid_low", 32'(valid_w[0]), 32'd0);
    check("gate_drained_bytes", 32'(hs_cnt), 32'd4);
    hold_r[0] = 1'b0;
    wait_drain(40, "gate_release_drained");
    check("gate_total_bytes", 32'(hs_cnt), 32'd8);
    ready_r[0] = 1'b0;
    tick(2);

    // Flush in BYTE1 with two reads in flight (L=2)
    active = 1;
    ready_r[1] = 1'b0;
    mark();
    push_word(16'hA1B2);
    n = 0;
    while (!valid_w[1] && n < 20) begin
      tick(1);
      n++;
    end
    check("flush_w0_valid", 32'(valid_w[1]), 32'd1);
    ready_r[1] = 1'b1;
    tick(1);
    ready_r[1] = 1'b0;
    check("flush_in_byte1", 32'(odd_w[1]), 32'd1);
    push_word(16'h1111);
    push_word(16'h2222);
    tick(3);
    check("flush_reads_issued", 32'(rd_cnt), 32'd3);
    flush_r[1] = 1'b1;
    exp_q.delete();
    tick(1);
    flush_r[1] = 1'b0;
    check("flush_valid_low", 32'(valid_w[1]), 32'd0);
    check("flush_level_zero", 32'(level_w[1]), 32'd0);
    check("flush_phase_byte0", 32'(odd_w[1]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("flush_discard", 32'(valid_w[1]), 32'd0);
    end
    push_word(16'hC3D4);
    ready_r[1] = 1'b1;
    wait_drain(30, "flush_next_drained");
    check("flush_total_bytes", 32'(hs_cnt), 32'd3);
    ready_r[1] = 1'b0;
    tick(2);

    // Async reset mid-stream with three words buffered
    active = 0;
    ready_r[0] = 1'b0;
    mark();
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    n = 0;
    while (level_w[0] != 3'd3 && n < 20) begin
      tick(1);
      n++;
    end
    check("rst_mid_level3", 32'(level_w[0]), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid_w[0]), 32'd0);
    check("rst_mid_odd", 32'(odd_w[0]), 32'd0);
    check("rst_mid_level", 32'(level_w[0]), 32'd0);
    check("rst_mid_rd_en", 32'(rd_en_w[0]), 32'd0);
    exp_q.delete();
    fq.delete();
    push_word(16'h9ABC);
    tick(3);
    check("rst_hold_rd_en", 32'(rd_en_w[0]), 32'd0);
    rst_n = 1'b1;
    ready_r[0] = 1'b1;
    wait_drain(30, "rst_post_drained");
    check("rst_post_bytes", 32'(hs_cnt), 32'd2);
    ready_r[0] = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
